// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file writeback port arbiter.
package wb_pkg;

    localparam int XLEN  = 32;
    localparam int RID_W = 5;

    typedef struct packed {
        logic [RID_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } wb_req_t;

    // One-hot register mask used to build the decode hazard vector
    function automatic logic [XLEN-1:0] onehot_rd(input logic [RID_W-1:0] rd);
        onehot_rd     = '0;
        onehot_rd[rd] = 1'b1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO that holds secondary writeback results until the shared port is free.
// Exposes per-entry valid/rd so the top level can publish the pending-register mask.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  wb_req_t                      push_req,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output wb_req_t                      head,
    output logic [DEPTH-1:0]             entry_valid,
    output logic [DEPTH-1:0][RID_W-1:0]  entry_rd
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   count;
    logic [AW-1:0] offset;
    wb_req_t       mem [DEPTH];

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_req;
        end
    end

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // A slot is live when its distance from the read pointer is below the occupancy
    always_comb begin
        offset      = '0;
        entry_valid = '0;
        entry_rd    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = AW'(i) - rd_ptr[AW-1:0];
            entry_valid[i] = ({1'b0, offset} < count);
            entry_rd[i]    = mem[i].rd;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Merges the in-order pipeline writeback with a queued secondary result source onto one port.
// Define WB_ARB_STARVE_EN to let an aged FIFO head stall the pipeline for one cycle.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p_valid,
    input  logic             p_wen,
    input  logic [RID_W-1:0] p_rd,
    input  logic [XLEN-1:0]  p_data,
    output logic             p_ready,
    input  logic             s_valid,
    input  logic [RID_W-1:0] s_rd,
    input  logic [XLEN-1:0]  s_data,
    output logic             s_ready,
    output logic             wb_reg_en,
    output logic [RID_W-1:0] wb_reg_id,
    output logic [XLEN-1:0]  wb_reg_data,
    output logic [XLEN-1:0]  pending_mask
);

    logic                             fifo_full;
    logic                             fifo_empty;
    logic                             fifo_push;
    logic                             fifo_pop;
    wb_req_t                          fifo_head;
    wb_req_t                          push_req;
    logic [FIFO_DEPTH-1:0]            entry_valid;
    logic [FIFO_DEPTH-1:0][RID_W-1:0] entry_rd;
    logic                             needs_port;
    logic                             starve_force;
    logic                             grant_p;

    // Writes to x0 are accepted from the source but never queued
    assign s_ready   = !fifo_full;
    assign fifo_push = s_valid && !fifo_full && (s_rd != '0);
    assign push_req  = '{rd: s_rd, data: s_data};

    wb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_req   (push_req),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fifo_head),
        .entry_valid(entry_valid),
        .entry_rd   (entry_rd)
    );

`ifdef WB_ARB_STARVE_EN
    logic [3:0] wait_cnt;

    assign starve_force = (wait_cnt >= 4'(MAX_WAIT)) && !fifo_empty;

    // Ages the current head; any pop hands the port a fresh head starting at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (fifo_pop || fifo_empty) begin
            wait_cnt <= '0;
        end else if (wait_cnt < 4'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end
`else
    assign starve_force = 1'b0;
`endif

    assign needs_port = p_valid && p_wen && (p_rd != '0);
    assign p_ready    = !starve_force;
    assign grant_p    = needs_port && !starve_force;
    assign fifo_pop   = !grant_p && !fifo_empty;

    // Registered write port; index and data hold when the port idles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_reg_en   <= 1'b0;
            wb_reg_id   <= '0;
            wb_reg_data <= '0;
        end else begin
            wb_reg_en <= grant_p || fifo_pop;
            if (grant_p) begin
                wb_reg_id   <= p_rd;
                wb_reg_data <= p_data;
            end else if (fifo_pop) begin
                wb_reg_id   <= fifo_head.rd;
                wb_reg_data <= fifo_head.data;
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i]) begin
                pending_mask = pending_mask | onehot_rd(entry_rd[i]);
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference of the arbitration rules.
module tb_wb_port_arbiter;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;
`ifdef WB_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p_valid = 1'b0;
    logic        p_wen = 1'b0;
    logic [4:0]  p_rd = '0;
    logic [31:0] p_data = '0;
    logic        p_ready;
    logic        s_valid = 1'b0;
    logic [4:0]  s_rd = '0;
    logic [31:0] s_data = '0;
    logic        s_ready;
    logic        wb_reg_en;
    logic [4:0]  wb_reg_id;
    logic [31:0] wb_reg_data;
    logic [31:0] pending_mask;

    int pass_cnt  = 0;
    int total_cnt = 0;

    wb_port_arbiter #(
        .FIFO_DEPTH(DEPTH),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .p_valid     (p_valid),
        .p_wen       (p_wen),
        .p_rd        (p_rd),
        .p_data      (p_data),
        .p_ready     (p_ready),
        .s_valid     (s_valid),
        .s_rd        (s_rd),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .wb_reg_en   (wb_reg_en),
        .wb_reg_id   (wb_reg_id),
        .wb_reg_data (wb_reg_data),
        .pending_mask(pending_mask)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference: queued results in arrival order, plus the cycle the current head reached the front
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    int          cyc = 0;
    int          head_since = 0;
    logic        m_en = 1'b0;
    logic [4:0]  m_id = '0;
    logic [31:0] m_data = '0;
    bit          exp_force;
    bit          needs;
    int          pre_size;
    ent_t        popped;

    function automatic logic [31:0] model_mask();
        logic [31:0] r = '0;
        foreach (mq[i]) r = r | (32'h1 << mq[i].rd);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            cyc        = 0;
            head_since = 0;
            m_en       = 1'b0;
            m_id       = '0;
            m_data     = '0;
        end else begin
            exp_force = STARVE && (mq.size() != 0) && ((cyc - head_since) >= MAX_WAIT);
            checkOutput("p_ready", 32'(p_ready), 32'(!exp_force));
            checkOutput("s_ready", 32'(s_ready), 32'(mq.size() < DEPTH));
            checkOutput("pending_mask", pending_mask, model_mask());
            checkOutput("wb_reg_en", 32'(wb_reg_en), 32'(m_en));
            checkOutput("wb_reg_id", 32'(wb_reg_id), 32'(m_id));
            checkOutput("wb_reg_data", wb_reg_data, m_data);
            needs = p_valid && p_wen && (p_rd != 0);
            if (needs && p_ready) begin
                checkOutput("granted_rd_pending", 32'(pending_mask[p_rd]), 32'd0);
            end
            pre_size = mq.size();
            if (needs && !exp_force) begin
                m_en   = 1'b1;
                m_id   = p_rd;
                m_data = p_data;
            end else if (pre_size != 0) begin
                popped     = mq.pop_front();
                m_en       = 1'b1;
                m_id       = popped.rd;
                m_data     = popped.data;
                head_since = cyc + 1;
            end else begin
                m_en = 1'b0;
            end
            if (s_valid && (pre_size < DEPTH) && (s_rd != 0)) begin
                mq.push_back('{rd: s_rd, data: s_data});
                if (pre_size == 0) head_since = cyc + 1;
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        p_valid = 1'b0;
        p_wen   = 1'b0;
        p_rd    = '0;
        p_data  = '0;
        s_valid = 1'b0;
        s_rd    = '0;
        s_data  = '0;
    endtask

    task automatic set_pipe(input logic [4:0] rd, input logic [31:0] data);
        p_valid = 1'b1;
        p_wen   = 1'b1;
        p_rd    = rd;
        p_data  = data;
    endtask

    task automatic set_sec(input logic [4:0] rd, input logic [31:0] data);
        s_valid = 1'b1;
        s_rd    = rd;
        s_data  = data;
    endtask

    // Random traffic; pipeline destinations avoid registers still pending in the queue
    task automatic applyStimulus(input int heavy);
        logic [31:0] mask;
        logic [4:0]  rd;
        mask    = model_mask();
        p_valid = ($urandom_range(0, 3) < heavy);
        p_wen   = ($urandom_range(0, 4) != 0);
        rd      = 5'($urandom);
        while (mask[rd]) rd = 5'($urandom);
        p_rd    = rd;
        p_data  = $urandom;
        s_valid = ($urandom_range(0, 2) == 0);
        s_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        s_data  = $urandom;
    endtask

    initial begin
        int stall_k;
        int write_k;
        int stall_n;
        int found;

        set_idle();
        rst = 1'b1;
        tick();
        tick();
        checkOutput("reset_wb_reg_en", 32'(wb_reg_en), 32'd0);
        checkOutput("reset_wb_reg_id", 32'(wb_reg_id), 32'd0);
        checkOutput("reset_wb_reg_data", wb_reg_data, 32'd0);
        checkOutput("reset_pending_mask", pending_mask, 32'd0);
        checkOutput("reset_s_ready", 32'(s_ready), 32'd1);
        checkOutput("reset_p_ready", 32'(p_ready), 32'd1);
        rst = 1'b0;
        tick();

        // Pipeline beat goes straight to the port one cycle later
        set_pipe(5'd5, 32'h11);
        tick();
        set_idle();
        checkOutput("prio_en", 32'(wb_reg_en), 32'd1);
        checkOutput("prio_id", 32'(wb_reg_id), 32'd5);
        checkOutput("prio_data", wb_reg_data, 32'h11);
        tick();
        checkOutput("prio_idle_en", 32'(wb_reg_en), 32'd0);
        checkOutput("prio_hold_id", 32'(wb_reg_id), 32'd5);

        // Secondary result drains through an idle port two cycles after the push
        set_sec(5'd7, 32'hAA);
        tick();
        set_idle();
        checkOutput("drain_mask_c1", pending_mask, 32'h0000_0080);
        checkOutput("drain_en_c1", 32'(wb_reg_en), 32'd0);
        tick();
        checkOutput("drain_en_c2", 32'(wb_reg_en), 32'd1);
        checkOutput("drain_id_c2", 32'(wb_reg_id), 32'd7);
        checkOutput("drain_data_c2", wb_reg_data, 32'hAA);
        checkOutput("drain_mask_c2", pending_mask, 32'd0);

        // Continuous pipeline writes against one queued entry
        set_pipe(5'd10, 32'd100);
        set_sec(5'd9, 32'h99);
        tick();
        s_valid = 1'b0;
        stall_k = -1;
        write_k = -1;
        stall_n = 0;
        for (int k = 1; k <= 12; k++) begin
            if (!p_ready) begin
                stall_n++;
                if (stall_k < 0) stall_k = k;
            end
            if (wb_reg_en && (wb_reg_id == 5'd9) && (write_k < 0)) write_k = k;
            set_pipe(5'(10 + (k % 4)), 32'(100 + k));
            tick();
        end
        checkOutput("starve_stall_count", 32'(stall_n), STARVE ? 32'd1 : 32'd0);
        checkOutput("starve_stall_cycle", 32'(stall_k), STARVE ? 32'd5 : 32'hFFFF_FFFF);
        checkOutput("starve_write_cycle", 32'(write_k), STARVE ? 32'd6 : 32'hFFFF_FFFF);
        set_idle();
        tick();
        tick();
        tick();

        // Fill the queue under a saturating pipeline, then hold a third result
        set_pipe(5'd20, 32'h200);
        set_sec(5'd12, 32'hC0);
        tick();
        set_pipe(5'd21, 32'h201);
        set_sec(5'd13, 32'hC1);
        tick();
        checkOutput("full_s_ready", 32'(s_ready), 32'd0);
        set_sec(5'd14, 32'hC2);
        found = 0;
        for (int j = 0; j < 20; j++) begin
            if (s_ready) begin
                found = 1;
                break;
            end
            if (j < 6) begin
                set_pipe(5'(20 + (j % 4)), 32'(j));
            end else begin
                p_valid = 1'b0;
                p_wen   = 1'b0;
            end
            tick();
        end
        checkOutput("full_wait_bounded", 32'(found), 32'd1);
        checkOutput("full_release_en", 32'(wb_reg_en), 32'd1);
        checkOutput("full_release_id", 32'(wb_reg_id), 32'd12);
        tick();
        set_idle();
        for (int j = 0; j < 5; j++) tick();

        // Store retiring alongside a queued rd=3, then an x0 result that must vanish
        set_sec(5'd3, 32'h33);
        tick();
        set_idle();
        p_valid = 1'b1;
        p_wen   = 1'b0;
        p_rd    = 5'd8;
        checkOutput("store_p_ready", 32'(p_ready), 32'd1);
        tick();
        set_idle();
        checkOutput("store_drain_en", 32'(wb_reg_en), 32'd1);
        checkOutput("store_drain_id", 32'(wb_reg_id), 32'd3);
        checkOutput("store_drain_data", wb_reg_data, 32'h33);
        set_sec(5'd0, 32'hDEAD);
        checkOutput("x0_s_ready", 32'(s_ready), 32'd1);
        tick();
        set_idle();
        checkOutput("x0_mask", pending_mask, 32'd0);
        for (int j = 0; j < 3; j++) begin
            checkOutput("x0_no_write", 32'(wb_reg_en), 32'd0);
            tick();
        end

        // Asynchronous reset with two results queued
        set_pipe(5'd21, 32'h321);
        set_sec(5'd17, 32'h17);
        tick();
        set_pipe(5'd22, 32'h322);
        set_sec(5'd18, 32'h18);
        tick();
        set_idle();
        checkOutput("rstmid_mask_before", pending_mask, 32'h0006_0000);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstmid_en", 32'(wb_reg_en), 32'd0);
        checkOutput("rstmid_id", 32'(wb_reg_id), 32'd0);
        checkOutput("rstmid_data", wb_reg_data, 32'd0);
        checkOutput("rstmid_mask", pending_mask, 32'd0);
        tick();
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            checkOutput("rstmid_no_write", 32'(wb_reg_en), 32'd0);
        end

        // Randomized traffic at several pipeline occupancies
        for (int n = 0; n < 3000; n++) begin
            applyStimulus((n < 1000) ? 4 : ((n < 2000) ? 2 : 3));
            tick();
        end
        set_idle();
        for (int j = 0; j < 8; j++) tick();
        checkOutput("final_mask_empty", pending_mask, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbiter for the single register-file write port that feeds decode. It merges two writeback sources: the in-order pipeline writeback stage, which has priority, and a secondary long-latency result source such as mul/div or an uncached load unit. Secondary results wait in a small FIFO, and an anti-starvation counter guarantees they eventually drain. The block sits between the writeback stage and the register file / decode read-bypass.

## Interface
Parameters:
- FIFO_DEPTH, 2: secondary result FIFO entries; power of two, ≥2.
- MAX_WAIT, 4: cycles a non-empty FIFO head may wait before the pipeline is stalled; range 1..15.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- p_valid, input, 1: the pipeline presents a retiring instruction.
- p_wen, input, 1: the pipeline instruction writes a register (0 for store/branch).
- p_rd, input, 5: pipeline destination register.
- p_data, input, 32: pipeline write data.
- p_ready, output, 1: the pipeline beat is accepted this cycle.
- s_valid, input, 1: the secondary source offers a result.
- s_rd, input, 5: secondary destination register.
- s_data, input, 32: secondary write data.
- s_ready, output, 1: the FIFO accepts the secondary result.
- wb_reg_en, output, 1: register-file write enable.
- wb_reg_id, output, 5: register-file write index.
- wb_reg_data, output, 32: register-file write data.
- pending_mask, output, 32: OR of one-hot rd over all valid FIFO entries; decode stalls readers and writers of these registers.

## Operation
- **Secondary push.** A push occurs when s_valid && s_ready.
  - s_ready = !full. It does not depend on a same-cycle pop.
  - A result with s_rd==0 is accepted and discarded; it is never stored.
- **Pipeline "needs port".** needs_port = p_valid && p_wen && p_rd!=0.
  - A pipeline beat with p_wen=0 or p_rd=0 is always accepted when p_ready=1 and does not use the port.
- **force.** force = (wait_cnt ≥ MAX_WAIT) && !empty.
- **p_ready.** p_ready = !force. It is a function of registered state only and is independent of p_valid.
- **Grant, evaluated each cycle:**
  - If needs_port && !force, grant the pipeline.
  - Else if !empty, pop the FIFO head and grant it.
  - Else grant nothing.
- **Output register.** Updates each cycle:
  - wb_reg_en <= granted.
  - wb_reg_id and wb_reg_data <= the granted source's fields, or hold their previous value when nothing is granted.
- **wait_cnt.** Clears on pop or when empty. Otherwise it increments while the head is not popped and saturates at MAX_WAIT.
- **pending_mask.** Recomputed combinationally from FIFO valid entries. An entry's bit clears in the cycle after its pop.
- **Write ordering.** WAW ordering between the pipeline and pending FIFO entries is decode's responsibility via pending_mask. The bench asserts that a granted p_rd never hits pending_mask.

## Timing
- **Reset values.** wb_reg_en=0, wb_reg_id=0, wb_reg_data=0, FIFO empty, wait_cnt=0, pending_mask=0, s_ready=1, p_ready=1.
- **Pipeline latency.** A pipeline beat accepted in cycle N appears on the write port in cycle N+1.
- **Secondary latency.** A secondary push in cycle N can be popped at earliest in cycle N+1 and written in cycle N+2. There is no FIFO bypass.
- **Full FIFO.** s_ready=0 for the whole cycle, even if a pop occurs in that cycle.
- **Empty FIFO with a pipeline beat without port use.** Port idle; wb_reg_en=0 the next cycle.
- **Force cycle.** p_ready=0, the head pops, and wait_cnt returns to 0. The pipeline resumes the next cycle, so it is stalled for exactly one cycle per MAX_WAIT contention window.
- **Reset mid-operation.** The FIFO is flushed and pending results are lost. This is acceptable because the pipeline is flushed together with the FIFO.

## Configuration
- **`WB_ARB_STARVE_EN` defined.** Anti-starvation is active as described above.
- **Not defined.**
  - Strict pipeline priority: force is tied to 0 and p_ready is tied to 1.
  - wait_cnt is not instantiated.
  - The FIFO drains only in cycles where needs_port=0.

## Structure
- **Package `wb_pkg`:**
  - XLEN=32 and RID_W=5.
  - typedef wb_req_t {rd[4:0], data[31:0]}.
  - Function `onehot_rd(rd)` returning the 32-bit mask.
- **Sub-module `wb_fifo`:**
  - Parameterised depth; pointers with a wrap bit.
  - Ports: push, pop, full, empty, head, and a per-entry valid/rd vector for pending_mask.
- **Top level.** The arbiter contains the grant logic, wait_cnt and the output register.

## Test plan
- **Pipeline priority.** Pipeline p_rd=5, p_data=0x11 with the FIFO empty → next cycle wb_reg_en=1, id=5, data=0x11.
- **FIFO drains in idle cycles.** Secondary s_rd=7, data=0xAA pushed at cycle 0; pipeline idle → pending_mask bit 7 set at cycle 1; write id=7 at cycle 2; mask clear at cycle 2.
- **Starvation.** Continuous pipeline writes with one FIFO entry, MAX_WAIT=4 → p_ready=0 in exactly one cycle, FIFO entry written in the cycle after that, then pipeline writes resume. Without `WB_ARB_STARVE_EN` the FIFO entry is never written.
- **Full FIFO.** Two pushes with DEPTH=2 while the pipeline saturates → s_ready=0. A third s_valid is held until a pop, then accepted the cycle after the pop.
- **Non-writing and x0 results.** A pipeline store (p_wen=0) coincides with a FIFO head rd=3 → rd=3 is written the next cycle with no stall. s_rd=0 is accepted and nothing is ever written.
- **Reset mid-operation.** rst asserted asynchronously with 2 FIFO entries → outputs and pending_mask drop to 0 immediately; nothing is written after deassertion.
